taito_pixel_serializer: RTL and testbench

// - Parametrised successor to the dual 8-bit sprite/tile shifter: NUM_CH parallel pixel-plane words of WIDTH bits are

---
 rtl/taito_video_pkg.sv | 14 +
 rtl/taito_pixel_serializer_if.sv | 32 +++
 rtl/pixser_hold_buf.sv | 33 +++
 rtl/taito_pixel_serializer.sv | 160 ++++++++++++++++
 tb/tb_taito_pixel_serializer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/taito_video_pkg.sv
// Shared video-pipeline types and default geometry for the pixel serializer.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package taito_video_pkg;

   localparam int DEF_NUM_CH = 2;
   localparam int DEF_WIDTH  = 8;

   typedef enum logic [0:0] {
      PS_IDLE  = 1'b0,
      PS_SHIFT = 1'b1
   } pixser_state_t;

endpackage

// File: rtl/taito_pixel_serializer_if.sv
// Parallel-word load channel from the tile/sprite ROM fetch into the pixel serializer.
// Latency: pure wiring, no registers.
// Backpressure: word moves on a clock edge only when load_valid && load_ready.
interface taito_pixel_serializer_if
   import taito_video_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int WIDTH  = DEF_WIDTH
);

   logic                    load_valid;
   logic                    load_ready;
   logic                    load_rev;
   logic [NUM_CH*WIDTH-1:0] load_data;

   // Fetch side offers words.
   modport master (
      output load_valid,
      output load_rev,
      output load_data,
      input  load_ready
   );

   // Serializer side accepts words.
   modport slave (
      input  load_valid,
      input  load_rev,
      input  load_data,
      output load_ready
   );

endinterface

// File: rtl/pixser_hold_buf.sv
// One-deep holding register (plane data + flip flag) with a full flag, for gapless reload.
// Latency: written word is visible on rd_data/rd_rev one cycle after wr_en.
// Backpressure: none internally; the owner must not write while full unless reading in the same cycle.
module pixser_hold_buf #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_rev,
   input  logic          rd_en,
   output logic          full,
   output logic [DW-1:0] rd_data,
   output logic          rd_rev
);

   // Capture on write; a read without a write just releases the slot.
   always_ff @(posedge clk) begin
      if (clear) begin
         full    <= 1'b0;
         rd_data <= '0;
         rd_rev  <= 1'b0;
      end else if (wr_en) begin
         full    <= 1'b1;
         rd_data <= wr_data;
         rd_rev  <= wr_rev;
      end else if (rd_en) begin
         full    <= 1'b0;
      end
   end

endmodule

// File: rtl/taito_pixel_serializer.sv
// Loads NUM_CH plane words together and shifts them out one bit per pix_ce, MSB- or LSB-first per word.
// Latency: word accepted at edge N is on out from edge N; the pix_ce of the accept cycle does not shift it.
// Backpressure: load_ready only in IDLE or on the last-bit step; with TAITO_PIXSER_HOLDBUF_EN, whenever the buffer is empty.
module taito_pixel_serializer
   import taito_video_pkg::*;
#(
   parameter int  NUM_CH = DEF_NUM_CH,
   parameter int  WIDTH  = DEF_WIDTH,
   localparam int CW     = $clog2(WIDTH)
) (
   input  logic                    clk,
   input  logic                    clear,
   input  logic                    pix_ce,
   taito_pixel_serializer_if.slave ld,
   output logic [NUM_CH-1:0]       out,
   output logic                    busy,
   output logic [CW-1:0]           bit_idx
);

   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   pixser_state_t           state_q, state_d;
   logic [CW-1:0]           idx_q, idx_d;
   logic                    rev_q;
   logic                    is_last;
   logic                    last_step;
   logic                    rdy;
   logic                    accept;
   logic                    load_word;
   logic                    drop_word;
   logic [NUM_CH*WIDTH-1:0] src_data;
   logic                    src_rev;

   assign is_last   = (idx_q == LAST_IDX);
   assign last_step = (state_q == PS_SHIFT) && pix_ce && is_last;

`ifdef TAITO_PIXSER_HOLDBUF_EN
   logic                    buf_wr;
   logic                    buf_rd;
   logic                    buf_full;
   logic [NUM_CH*WIDTH-1:0] buf_data;
   logic                    buf_rev;

   pixser_hold_buf #(
      .DW (NUM_CH*WIDTH)
   ) u_hold_buf (
      .clk     (clk),
      .clear   (clear),
      .wr_en   (buf_wr),
      .wr_data (ld.load_data),
      .wr_rev  (ld.load_rev),
      .rd_en   (buf_rd),
      .full    (buf_full),
      .rd_data (buf_data),
      .rd_rev  (buf_rev)
   );

   assign rdy = !buf_full;
`else
   // Without a buffer a word can only land when the shifter is free this cycle.
   assign rdy = (state_q == PS_IDLE) || last_step;
`endif

   assign ld.load_ready = rdy;
   assign accept        = ld.load_valid && rdy;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (clear) state_q <= PS_IDLE;
      else       state_q <= state_d;
   end

   // Next state, bit counter and word-source selection.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      load_word = 1'b0;
      drop_word = 1'b0;
      src_data  = ld.load_data;
      src_rev   = ld.load_rev;
`ifdef TAITO_PIXSER_HOLDBUF_EN
      buf_wr    = 1'b0;
      buf_rd    = 1'b0;
`endif
      unique case (state_q)
         PS_IDLE: begin
            if (accept) begin
               load_word = 1'b1;
               state_d   = PS_SHIFT;
               idx_d     = '0;
            end
         end
         PS_SHIFT: begin
`ifdef TAITO_PIXSER_HOLDBUF_EN
            // Mid-word arrivals park in the buffer; overridden below when they go straight in.
            buf_wr = accept;
`endif
            if (pix_ce) begin
               if (!is_last) begin
                  idx_d = idx_q + CW'(1);
               end else begin
                  idx_d = '0;
`ifdef TAITO_PIXSER_HOLDBUF_EN
                  if (buf_full) begin
                     buf_rd    = 1'b1;
                     load_word = 1'b1;
                     src_data  = buf_data;
                     src_rev   = buf_rev;
                  end else if (accept) begin
                     buf_wr    = 1'b0;
                     load_word = 1'b1;
                  end else begin
                     drop_word = 1'b1;
                     state_d   = PS_IDLE;
                  end
`else
                  if (accept) begin
                     load_word = 1'b1;
                  end else begin
                     drop_word = 1'b1;
                     state_d   = PS_IDLE;
                  end
`endif
               end
            end
         end
      endcase
   end

   // Bit index and per-word flip flag.
   always_ff @(posedge clk) begin
      if (clear) begin
         idx_q <= '0;
         rev_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         if (load_word)      rev_q <= src_rev;
         else if (drop_word) rev_q <= 1'b0;
      end
   end

   // Per-plane word register and serial bit select.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_plane
      logic [WIDTH-1:0] plane_q;

      // Plane word: loaded on accept or buffer transfer, zeroed when the stream ends.
      always_ff @(posedge clk) begin
         if (clear)          plane_q <= '0;
         else if (load_word) plane_q <= src_data[c*WIDTH +: WIDTH];
         else if (drop_word) plane_q <= '0;
      end

      assign out[c] = (state_q == PS_SHIFT) &&
                      (rev_q ? plane_q[idx_q] : plane_q[LAST_IDX - idx_q]);
   end

   assign busy    = (state_q == PS_SHIFT);
   assign bit_idx = idx_q;

endmodule

// File: tb/tb_taito_pixel_serializer.sv
// Directed bench for the pixel serializer with a scoreboard of expected serial bits.
// Latency: one expected entry is consumed per shift step (busy && pix_ce).
// Backpressure: loads wait on load_ready with a bounded cycle budget.
module tb_taito_pixel_serializer;

   logic       clk = 1'b0;
   logic       clear;
   logic       pix_ce;
   logic [1:0] out;
   logic       busy;
   logic [2:0] bit_idx;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [1:0] o;
      logic [2:0] idx;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   logic gap_watch = 1'b0;
   int   gap_cnt   = 0;

   taito_pixel_serializer_if #(.NUM_CH(2), .WIDTH(8)) ld_if ();

   taito_pixel_serializer #(
      .NUM_CH (2),
      .WIDTH  (8)
   ) dut (
      .clk     (clk),
      .clear   (clear),
      .pix_ce  (pix_ce),
      .ld      (ld_if.slave),
      .out     (out),
      .busy    (busy),
      .bit_idx (bit_idx)
   );

   always #5 clk = ~clk;

   // Monitor: every shift step consumes one expected (out, bit_idx) pair.
   initial begin
      forever begin
         @(negedge clk);
         if (gap_watch && !busy) gap_cnt++;
         if (!clear && busy && pix_ce) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL stream: got out=%b idx=%0d, required no active bit", out, bit_idx);
            end else begin
               mon_e = exp_q.pop_front();
               if (out !== mon_e.o || bit_idx !== mon_e.idx) begin
                  n_fail++;
                  $display("FAIL stream: got out=%b idx=%0d, required out=%b idx=%0d",
                           out, bit_idx, mon_e.o, mon_e.idx);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   // Offer a word until accepted; e0/e1 hold each plane's serial order, first bit in the MSB.
   task automatic offer(input logic [15:0] d, input logic r, input logic [7:0] e0, input logic [7:0] e1);
      int   n;
      logic ok;
      exp_t e;
      n  = 0;
      ok = 1'b0;
      ld_if.load_valid = 1'b1;
      ld_if.load_data  = d;
      ld_if.load_rev   = r;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (ld_if.load_ready) ok = 1'b1;
         n++;
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: got load_ready=0 for %0d cycles, required 1", n);
      end else begin
         for (int i = 0; i < 8; i++) begin
            e.o   = {e1[7-i], e0[7-i]};
            e.idx = 3'(i);
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      ld_if.load_valid = 1'b0;
      ld_if.load_data  = '0;
      ld_if.load_rev   = 1'b0;
   endtask

   // Wait for the stream to finish, then check idle outputs and scoreboard drain.
   task automatic wait_idle(input string name);
      int   n;
      logic done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 200) begin
         @(negedge clk);
         if (!busy) done = 1'b1;
         n++;
      end
      check({name, "_idle_busy"}, {7'd0, busy}, 8'h00);
      check({name, "_idle_out"},  {6'd0, out},  8'h00);
      check({name, "_idle_idx"},  {5'd0, bit_idx}, 8'h00);
      check({name, "_drained"},   8'(exp_q.size()), 8'h00);
      @(posedge clk);
      #1;
   endtask

   logic [3:0] ce_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic [2:0] idx_pat [4] = '{3'd0, 3'd1, 3'd1, 3'd1};
   logic [1:0] out_pat [4] = '{2'b10, 2'b01, 2'b01, 2'b01};

   initial begin
      clear            = 1'b1;
      pix_ce           = 1'b1;
      ld_if.load_valid = 1'b0;
      ld_if.load_data  = '0;
      ld_if.load_rev   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check("rst_out",   {6'd0, out},     8'h00);
      check("rst_busy",  {7'd0, busy},    8'h00);
      check("rst_idx",   {5'd0, bit_idx}, 8'h00);
      check("rst_ready", {7'd0, ld_if.load_ready}, 8'h01);
      @(posedge clk);
      #1;

      // Plane0 A5, plane1 3C, MSB-first then LSB-first.
      offer({8'h3C, 8'hA5}, 1'b0, 8'b10100101, 8'b00111100);
      wait_idle("a5_msb");
      offer({8'h3C, 8'hA5}, 1'b1, 8'b10100101, 8'b00111100);
      wait_idle("a5_lsb");

      // Asymmetric words expose the flip direction.
      offer({8'h80, 8'h01}, 1'b1, 8'b10000000, 8'b00000001);
      wait_idle("01_lsb");
      offer({8'h80, 8'h01}, 1'b0, 8'b00000001, 8'b10000000);
      wait_idle("01_msb");

      // Pixel-enable gating: index moves only on enabled cycles, output holds between.
      pix_ce = 1'b0;
      offer({8'hBF, 8'h40}, 1'b0, 8'b01000000, 8'b10111111);
      for (int k = 0; k < 4; k++) begin
         pix_ce = ce_pat[k][0];
         @(negedge clk);
         check($sformatf("ce_idx%0d", k), {5'd0, bit_idx}, {5'd0, idx_pat[k]});
         check($sformatf("ce_out%0d", k), {6'd0, out},     {6'd0, out_pat[k]});
         @(posedge clk);
         #1;
      end
      pix_ce = 1'b1;
      wait_idle("ce_gate");

      // Back-to-back: FF then 00 with no gap on the last step.
      offer({8'hFF, 8'hFF}, 1'b0, 8'hFF, 8'hFF);
      gap_watch = 1'b1;
`ifndef TAITO_PIXSER_HOLDBUF_EN
      ld_if.load_valid = 1'b1;
      ld_if.load_data  = 16'h0000;
      @(negedge clk);
      check("midword_refused", {7'd0, ld_if.load_ready}, 8'h00);
`endif
      offer(16'h0000, 1'b0, 8'h00, 8'h00);
      repeat (7) @(negedge clk);
      check("b2b_busy_end", {7'd0, busy}, 8'h01);
      gap_watch = 1'b0;
      check("b2b_gap", 8'(gap_cnt), 8'h00);
      wait_idle("b2b");

`ifdef TAITO_PIXSER_HOLDBUF_EN
      // Three consecutive offers: second parks in the buffer, third stalls until it drains.
      gap_cnt = 0;
      offer({8'h3C, 8'hA5}, 1'b0, 8'b10100101, 8'b00111100);
      gap_watch = 1'b1;
      offer({8'h80, 8'h01}, 1'b1, 8'b10000000, 8'b00000001);
      ld_if.load_valid = 1'b1;
      ld_if.load_data  = {8'hBF, 8'h40};
      @(negedge clk);
      check("buf_full_stall", {7'd0, ld_if.load_ready}, 8'h00);
      offer({8'hBF, 8'h40}, 1'b0, 8'b01000000, 8'b10111111);
      repeat (12) @(negedge clk);
      gap_watch = 1'b0;
      check("buf_gap", 8'(gap_cnt), 8'h00);
      wait_idle("buf3");
`endif

      // Clear mid-word wins over an active shift.
      offer({8'hFF, 8'hFF}, 1'b0, 8'hFF, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      check("pre_clear_out", {6'd0, out}, 8'h03);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("clr_out",   {6'd0, out},     8'h00);
      check("clr_busy",  {7'd0, busy},    8'h00);
      check("clr_idx",   {5'd0, bit_idx}, 8'h00);
      check("clr_ready", {7'd0, ld_if.load_ready}, 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
